alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// - Initiator side of the n-bit ALU: accepts one command over a valid/ready handshake,
//   drives ALU operand/control pins, captures ALUResult/flags, returns them over valid/ready.
// - Multi-bit shifts are executed as repeated single-bit ALU passes with result feedback.
// - Sits between the datapath control logic and one combinational ALU instance.
// PARAMETERS
// - N   4   operand/result width; must match the connected ALU's n
// PORTS
// - clk          in   1  single clock; all state on rising edge
// - rst          in   1  synchronous, active-high reset
// - cmd_valid    in   1  command present
// - cmd_ready    out  1  sequencer can accept (high only in IDLE)
// - cmd_op       in   4  ALUControl opcode (alu_pkg::alu_op_e)
// - cmd_a        in   N  operand A
// - cmd_b        in   N  operand B; shift amount for SL/SR
// - cmd_flag_in  in   1  carry-in / shift fill bit / INC,DEC,NOT operand select
// - alu_a        out  N  to ALUA
// - alu_b        out  N  to ALUB
// - alu_flag_in  out  1  to ALUFlagIn
// - alu_control  out  4  to ALUControl
// - alu_result   in   N  from ALUResult
// - alu_c, alu_z in   1  from ALUFlags.C / ALUFlags.Z
// - rsp_valid    out  1  response present
// - rsp_ready    in   1  consumer accepts response
// - rsp_result   out  N  final result
// - rsp_c, rsp_z out  1  final carry / zero flags
// - rsp_err      out  1  opcode 10..15 (unsupported)
// BEHAVIOUR
// - Opcodes: 0 AND,1 OR,2 ADD,3 INC,4 DEC,5 NOT,6 SUB,7 XOR,8 SL,9 SR. ALU SL/SR contract is a
//   1-bit shift: SL C=A[N-1], fill LSB with flag_in; SR C=A[0], fill MSB with flag_in.
// - FSM IDLE -> EXEC -> RESP -> IDLE. Reset: IDLE; all outputs and registers 0, cmd_ready=1.
// - IDLE: cmd_ready=1. On cmd_valid: latch op/a/b/flag_in; pass count = 1 for ops 0..7,
//   min(cmd_b,N) for SL/SR. Count 0 (shift by 0) or op>=10: skip EXEC, go RESP directly with
//   result=cmd_a (shift-0: c=0, z=(cmd_a==0)) or result=0,c=0,z=1,err=1 (illegal op).
// - EXEC: alu_a=working reg, alu_b=latched b (1 for shifts), alu_flag_in, alu_control=op driven
//   from registers; each edge captures alu_result into working reg, alu_c/alu_z into flag regs,
//   decrements count; last pass -> RESP. rsp_c forced 0 for AND/OR/INC/DEC/NOT/XOR.
// - Latency: rsp_valid rises (passes+1) cycles after the accepting edge; 1 cycle when skipped.
// - RESP: rsp_valid=1, rsp_* stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE, rsp_valid=0
//   next cycle. No new command accepted in same cycle (cmd_ready=0 outside IDLE).
// - alu_* outputs 0 outside EXEC. rst in any state aborts the operation; response discarded.
// - cmd_valid outside IDLE is ignored (not lost: sender holds it per handshake rules).
// STRUCTURE
// - alu_pkg: alu_op_e enum (values above), ALU_OP_LAST=9, state enum {IDLE,EXEC,RESP}.
// - One sub-module natural: alu_seq_fsm (state, pass counter, handshake); datapath regs in top.
// TESTING (N=4, one ALU instance in bench)
// - ADD a=7,b=9,fin=0 -> 1 pass; result=0,c=1,z=1; rsp_valid 2 cycles after accept.
// - SL a=4'b0011,b=2,fin=0 -> 2 passes; result=4'b1100,c=0,z=0; rsp_valid 3 cycles after accept.
// - SR a=4'b1001,b=7,fin=1 -> clamped 4 passes; result=4'b1111,c=1; rsp_valid 5 cycles after.
// - SL a=4'hA,b=0 -> no ALU pass; result=4'hA,c=0,z=0; rsp_valid 1 cycle after accept.
// - Hold rsp_ready=0 5 cycles -> rsp_* stable, cmd_ready=0; release -> cmd_ready=1 next cycle.
// - rst in EXEC of 4-pass shift -> next cycle rsp_valid=0, alu_*=0, cmd_ready=1; op=4'hF ->
//   rsp_err=1, result=0, z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the ALU operation sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_INC = 4'd3,
    OP_DEC = 4'd4,
    OP_NOT = 4'd5,
    OP_SUB = 4'd6,
    OP_XOR = 4'd7,
    OP_SL  = 4'd8,
    OP_SR  = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= ALU_OP_LAST;
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SL) || (op == OP_SR);
  endfunction

  // Only arithmetic and shift results carry a meaningful C flag.
  function automatic logic op_keeps_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SL) || (op == OP_SR);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_fsm.sv
// Control FSM of the sequencer: handshakes, state and ALU pass counter.
module alu_seq_fsm
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_b,
  input  logic         rsp_ready,
  output logic         cmd_ready,
  output logic         rsp_valid,
  output logic         accept,
  output logic         exec
);

  localparam int CW = $clog2(N + 1);

  seq_state_e    state_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] pass_cnt;

  // Shifts run one ALU pass per bit, clamped to N; illegal opcodes need no pass.
  always_comb begin
    pass_cnt = '0;
    if (op_legal(cmd_op)) begin
      if (op_is_shift(cmd_op)) begin
        if (int'(cmd_b) >= N) pass_cnt = CW'(N);
        else                  pass_cnt = CW'(cmd_b);
      end else begin
        pass_cnt = CW'(1);
      end
    end
  end

  assign accept = (state_reg == IDLE) && cmd_valid;
  assign exec   = (state_reg == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            count_reg <= pass_cnt;
            if (pass_cnt == '0) begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state_reg <= EXEC;
            end
          end
        end
        EXEC: begin
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU from a command handshake, iterating shifts bit by bit.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_flag_in,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_flag_in,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_c,
  input  logic         alu_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_c,
  output logic         rsp_z,
  output logic         rsp_err
);

  logic         accept;
  logic         exec;
  alu_op_e      op_reg;
  logic [N-1:0] b_reg;
  logic         fin_reg;
  logic [N-1:0] work_reg;
  logic         c_reg;
  logic         z_reg;
  logic         err_reg;

  alu_seq_fsm #(.N(N)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .rsp_ready (rsp_ready),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .accept    (accept),
    .exec      (exec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= OP_AND;
      b_reg    <= '0;
      fin_reg  <= 1'b0;
      work_reg <= '0;
      c_reg    <= 1'b0;
      z_reg    <= 1'b0;
      err_reg  <= 1'b0;
    end else if (accept) begin
      op_reg  <= alu_op_e'(cmd_op);
      // The ALU shifts by exactly one bit per pass, so B is pinned to 1.
      b_reg   <= op_is_shift(cmd_op) ? N'(1) : cmd_b;
      fin_reg <= cmd_flag_in;
      c_reg   <= 1'b0;
      if (op_legal(cmd_op)) begin
        work_reg <= cmd_a;
        z_reg    <= (cmd_a == '0);
        err_reg  <= 1'b0;
      end else begin
        work_reg <= '0;
        z_reg    <= 1'b1;
        err_reg  <= 1'b1;
      end
    end else if (exec) begin
      work_reg <= alu_result;
      c_reg    <= op_keeps_carry(op_reg) ? alu_c : 1'b0;
      z_reg    <= alu_z;
    end
  end

  assign alu_a       = exec ? work_reg : '0;
  assign alu_b       = exec ? b_reg : '0;
  assign alu_flag_in = exec & fin_reg;
  assign alu_control = exec ? op_reg : 4'd0;

  assign rsp_result = work_reg;
  assign rsp_c      = c_reg;
  assign rsp_z      = z_reg;
  assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_flag_in;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_flag_in;
  logic [3:0] alu_control;
  logic [3:0] alu_result;
  logic       alu_c;
  logic       alu_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_c;
  logic       rsp_z;
  logic       rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_flag_in (cmd_flag_in),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_flag_in (alu_flag_in),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_c       (rsp_c),
    .rsp_z       (rsp_z),
    .rsp_err     (rsp_err)
  );

  // Behavioural ALU; logic ops drive C=1 so the sequencer's carry masking is visible.
  logic [4:0] wide;
  logic [3:0] opnd;
  always_comb begin
    wide       = '0;
    opnd       = alu_flag_in ? alu_b : alu_a;
    alu_result = '0;
    alu_c      = 1'b0;
    case (alu_control)
      4'd0: begin alu_result = alu_a & alu_b; alu_c = 1'b1; end
      4'd1: begin alu_result = alu_a | alu_b; alu_c = 1'b1; end
      4'd2: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_flag_in};
        alu_result = wide[3:0]; alu_c = wide[4];
      end
      4'd3: begin wide = {1'b0, opnd} + 5'd1; alu_result = wide[3:0]; alu_c = wide[4]; end
      4'd4: begin wide = {1'b0, opnd} - 5'd1; alu_result = wide[3:0]; alu_c = wide[4]; end
      4'd5: begin alu_result = ~opnd; alu_c = 1'b1; end
      4'd6: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = wide[3:0]; alu_c = wide[4];
      end
      4'd7: begin alu_result = alu_a ^ alu_b; alu_c = 1'b1; end
      4'd8: begin alu_result = {alu_a[2:0], alu_flag_in}; alu_c = alu_a[3]; end
      4'd9: begin alu_result = {alu_flag_in, alu_a[3:1]}; alu_c = alu_a[0]; end
      default: begin alu_result = '0; alu_c = 1'b0; end
    endcase
    alu_z = (alu_result == 4'd0);
  end

  // Called at a negedge; returns with the response still pending (rsp_ready low).
  task automatic send_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic fin, output int lat, output logic [3:0] r,
                          output logic c, output logic z, output logic err);
    int waited;
    waited      = 0;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_flag_in = fin;
    cmd_valid   = 1'b1;
    rsp_ready   = 1'b0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    r   = rsp_result;
    c   = rsp_c;
    z   = rsp_z;
    err = rsp_err;
    $display("cmd op=%0d a=%h b=%h fin=%0b -> lat=%0d result=%h c=%0b z=%0b err=%0b",
             op, a, b, fin, lat, r, c, z, err);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_flag_in = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (alu_control !== 4'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_flag_in !== 1'b0) begin
      errors++; $display("FAIL reset_alu_pins ctl=%h a=%h b=%h fin=%0b exp all 0", alu_control, alu_a, alu_b, alu_flag_in); end
    checks++; if (rsp_result !== 4'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got result=%h err=%0b exp 0/0", rsp_result, rsp_err); end
  endtask

  task automatic test_add();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd2, 4'd7, 4'd9, 1'b0, lat, r, c, z, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL add_result got=%h exp=0", r); end
    checks++; if (c !== 1'b1 || z !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL add_flags got c=%0b z=%0b err=%0b exp 1/1/0", c, z, e); end
    finish_rsp();
  endtask

  task automatic test_shift_left();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd8, 4'b0011, 4'd2, 1'b0, lat, r, c, z, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sl_latency got=%0d exp=3", lat); end
    checks++; if (r !== 4'b1100) begin errors++; $display("FAIL sl_result got=%b exp=1100", r); end
    checks++; if (c !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL sl_flags got c=%0b z=%0b exp 0/0", c, z); end
    finish_rsp();
  endtask

  task automatic test_shift_right_clamp();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd9, 4'b1001, 4'd7, 1'b1, lat, r, c, z, e);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sr_latency got=%0d exp=5", lat); end
    checks++; if (r !== 4'b1111) begin errors++; $display("FAIL sr_result got=%b exp=1111", r); end
    checks++; if (c !== 1'b1 || z !== 1'b0) begin errors++; $display("FAIL sr_flags got c=%0b z=%0b exp 1/0", c, z); end
    finish_rsp();
  endtask

  task automatic test_shift_zero();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd8, 4'hA, 4'd0, 1'b0, lat, r, c, z, e);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sh0_latency got=%0d exp=1", lat); end
    checks++; if (r !== 4'hA) begin errors++; $display("FAIL sh0_result got=%h exp=a", r); end
    checks++; if (c !== 1'b0 || z !== 1'b0 || e !== 1'b0) begin
      errors++; $display("FAIL sh0_flags got c=%0b z=%0b err=%0b exp 0/0/0", c, z, e); end
    finish_rsp();
  endtask

  task automatic test_logic_ops();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd0, 4'hC, 4'hA, 1'b0, lat, r, c, z, e);
    checks++; if (r !== 4'h8 || c !== 1'b0 || z !== 1'b0) begin
      errors++; $display("FAIL and_out got r=%h c=%0b z=%0b exp 8/0/0", r, c, z); end
    finish_rsp();
    send_cmd(4'd7, 4'h5, 4'h5, 1'b0, lat, r, c, z, e);
    checks++; if (r !== 4'h0 || c !== 1'b0 || z !== 1'b1) begin
      errors++; $display("FAIL xor_out got r=%h c=%0b z=%0b exp 0/0/1", r, c, z); end
    finish_rsp();
    send_cmd(4'd3, 4'h2, 4'hF, 1'b1, lat, r, c, z, e);
    checks++; if (r !== 4'h0 || c !== 1'b0 || z !== 1'b1 || lat !== 2) begin
      errors++; $display("FAIL inc_b_out got r=%h c=%0b z=%0b lat=%0d exp 0/0/1/2", r, c, z, lat); end
    finish_rsp();
    send_cmd(4'd6, 4'h3, 4'h5, 1'b0, lat, r, c, z, e);
    checks++; if (r !== 4'hE || c !== 1'b1 || z !== 1'b0) begin
      errors++; $display("FAIL sub_out got r=%h c=%0b z=%0b exp e/1/0", r, c, z); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd2, 4'd3, 4'd4, 1'b0, lat, r, c, z, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd7 || rsp_c !== 1'b0 || rsp_z !== 1'b0) begin
        errors++; $display("FAIL hold_rsp cyc=%0d got v=%0b r=%h c=%0b z=%0b exp 1/7/0/0",
                           i, rsp_valid, rsp_result, rsp_c, rsp_z); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_cmd_ready cyc=%0d got=%0b exp=0", i, cmd_ready); end
    end
    finish_rsp();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL release got cmd_ready=%0b rsp_valid=%0b exp 1/0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_reset_in_exec();
    cmd_op = 4'd9; cmd_a = 4'b1001; cmd_b = 4'd7; cmd_flag_in = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (alu_control !== 4'd9 || alu_b !== 4'd1 || alu_a !== 4'b1001 || alu_flag_in !== 1'b1) begin
      errors++; $display("FAIL exec_pins got ctl=%h a=%b b=%h fin=%0b exp 9/1001/1/1",
                         alu_control, alu_a, alu_b, alu_flag_in); end
    @(negedge clk);
    checks++; if (alu_a !== 4'b1100) begin errors++; $display("FAIL exec_feedback got a=%b exp=1100", alu_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort_hs got rsp_valid=%0b cmd_ready=%0b exp 0/1", rsp_valid, cmd_ready); end
    checks++; if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_control !== 4'd0 || alu_flag_in !== 1'b0) begin
      errors++; $display("FAIL abort_alu got a=%h b=%h ctl=%h fin=%0b exp all 0", alu_a, alu_b, alu_control, alu_flag_in); end
    repeat (6) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got rsp_valid=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_illegal();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'hF, 4'h6, 4'h3, 1'b0, lat, r, c, z, e);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (e !== 1'b1 || r !== 4'd0 || z !== 1'b1 || c !== 1'b0) begin
      errors++; $display("FAIL illegal_rsp got err=%0b r=%h z=%0b c=%0b exp 1/0/1/0", e, r, z, c); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] r; logic c, z, e;
    send_cmd(4'd5, 4'h6, 4'h0, 1'b0, lat, r, c, z, e);
    checks++; if (r !== 4'h9 || c !== 1'b0 || e !== 1'b0) begin
      errors++; $display("FAIL b2b_not got r=%h c=%0b err=%0b exp 9/0/0", r, c, e); end
    finish_rsp();
    send_cmd(4'd4, 4'h0, 4'h0, 1'b0, lat, r, c, z, e);
    checks++; if (r !== 4'hF || c !== 1'b0 || z !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL b2b_dec got r=%h c=%0b z=%0b lat=%0d exp f/0/0/2", r, c, z, lat); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift_left();
    test_shift_right_clamp();
    test_shift_zero();
    test_logic_ops();
    test_backpressure();
    test_reset_in_exec();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
